// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   PORT_C/D    : port identifiers used for owner/winner tracking
//   DEF_*       : default address/data widths of the instruction/data RAM
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick.
//   c_req, d_req : requests from port C and port D
//   owner        : last granted port (PORT_C/PORT_D)
//   win_valid    : at least one request present
//   win_id       : winning port; on a tie the port that is not the owner wins
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic owner,
  output logic win_valid,
  output logic win_id
);

  always_comb begin
    win_valid = c_req | d_req;
    if (c_req && d_req) begin
      win_id = ~owner;
    end else if (d_req) begin
      win_id = PORT_D;
    end else begin
      win_id = PORT_C;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data RAM between the CPU port (C) and the
// debug/program loader port (D). One word per grant, fixed read latency.
//   clk, rst                 : system clock, synchronous active-high reset
//   c_req/we/addr/wdata      : CPU request; held stable until c_gnt
//   c_gnt, c_done, c_rdata   : accept pulse, completion pulse, registered read data
//   d_*                      : same for the loader port
//   ram_addr/wdata/we        : RAM command, driven from the latched request
//   ram_rdata                : RAM read data, valid RD_LAT cycles after the address
//   busy                     : FSM not in IDLE
//   owner                    : last granted port (0=C, 1=D)
//
// state  | meaning
// IDLE   | arbitrate; latch winner's command
// ACCESS | winner's gnt; RAM samples address/we/wdata
// WAIT   | RD_LAT cycles of read latency; capture on the last one
// DONE   | winner's done pulse
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic win_valid;
  logic win_id;

  rr_arbiter2 u_rr (
    .c_req    (c_req),
    .d_req    (d_req),
    .owner    (owner_q),
    .win_valid(win_valid),
    .win_id   (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= PORT_D;
      win_q     <= PORT_C;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_done    = 1'b0;
    d_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          win_d   = win_id;
          owner_d = win_id;
          we_d    = (win_id == PORT_D) ? d_we    : c_we;
          addr_d  = (win_id == PORT_D) ? d_addr  : c_addr;
          wdata_d = (win_id == PORT_D) ? d_wdata : c_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        c_gnt = (win_q == PORT_C);
        d_gnt = (win_q == PORT_D);
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (win_q == PORT_D) d_rdata_d = ram_rdata;
          else                 c_rdata_d = ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        c_done  = (win_q == PORT_C);
        d_done  = (win_q == PORT_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset arriving in ACCESS must keep the write from reaching the RAM on
  // that same edge, so the strobe is qualified with rst.
  assign ram_we    = (state_q == ACCESS) && we_q && !rst;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: RD_LAT=1, instance 1: RD_LAT=3
  logic        rst     [2];
  logic        c_req   [2];
  logic        c_we    [2];
  logic [8:0]  c_addr  [2];
  logic [31:0] c_wdata [2];
  logic        c_gnt   [2];
  logic        c_done  [2];
  logic [31:0] c_rdata [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [8:0]  d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt   [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic [8:0]  ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic        ram_we    [2];
  logic [31:0] ram_rdata [2];
  logic        busy      [2];
  logic        owner     [2];

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem  [512];
    logic [31:0] pipe [L];

    initial for (int k = 0; k < 512; k++) mem[k] = 32'h0;

    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_addr[g]];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[L-1];

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(L)) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .c_req    (c_req[g]),
      .c_we     (c_we[g]),
      .c_addr   (c_addr[g]),
      .c_wdata  (c_wdata[g]),
      .c_gnt    (c_gnt[g]),
      .c_done   (c_done[g]),
      .c_rdata  (c_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_done   (d_done[g]),
      .d_rdata  (d_rdata[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_we   (ram_we[g]),
      .ram_rdata(ram_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );
  end

  typedef struct {
    int          inst;
    bit          port;
    int          cyc;
    bit          rd;
    logic [31:0] data;
    logic [31:0] oth;
  } ev_t;

  ev_t gq[$];
  ev_t dq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_gnt(int i, bit p, int c);
    ev_t e;
    e.inst = i; e.port = p; e.cyc = c; e.rd = 1'b0; e.data = '0; e.oth = '0;
    gq.push_back(e);
  endtask

  task automatic exp_done(int i, bit p, int c, bit rd, logic [31:0] data, logic [31:0] oth);
    ev_t e;
    e.inst = i; e.port = p; e.cyc = c; e.rd = rd; e.data = data; e.oth = oth;
    dq.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every gnt/done the DUTs present.
  ev_t e_m;
  bit  gv, dv;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (c_gnt[i] || d_gnt[i]) check("gnt_exclusive", 64'(c_gnt[i] & d_gnt[i]), 64'd0);
      if (c_done[i] || d_done[i]) check("done_exclusive", 64'(c_done[i] & d_done[i]), 64'd0);
      for (int p = 0; p < 2; p++) begin
        gv = (p == 1) ? d_gnt[i]  : c_gnt[i];
        dv = (p == 1) ? d_done[i] : c_done[i];
        if (gv) begin
          if (gq.size() == 0) begin
            check("gnt_unexpected", 64'(p + 2 * i), 64'hFFFF);
          end else begin
            e_m = gq.pop_front();
            check("gnt_inst",  64'(i),   64'(e_m.inst));
            check("gnt_port",  64'(p),   64'(e_m.port));
            check("gnt_cycle", 64'(cyc), 64'(e_m.cyc));
          end
        end
        if (dv) begin
          if (dq.size() == 0) begin
            check("done_unexpected", 64'(p + 2 * i), 64'hFFFF);
          end else begin
            e_m = dq.pop_front();
            check("done_inst",  64'(i),   64'(e_m.inst));
            check("done_port",  64'(p),   64'(e_m.port));
            check("done_cycle", 64'(cyc), 64'(e_m.cyc));
            if (e_m.rd) begin
              check("done_rdata", 64'((p == 1) ? d_rdata[i] : c_rdata[i]), 64'(e_m.data));
              check("other_rdata", 64'((p == 1) ? c_rdata[i] : d_rdata[i]), 64'(e_m.oth));
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst(int i);
    rst[i] = 1'b1;
    @(posedge clk);
    #1;
    rst[i] = 1'b0;
  endtask

  int t;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy",      64'(busy[i]),      64'd0);
      check("rst_owner",     64'(owner[i]),     64'd1);
      check("rst_ram_we",    64'(ram_we[i]),    64'd0);
      check("rst_ram_addr",  64'(ram_addr[i]),  64'd0);
      check("rst_ram_wdata", 64'(ram_wdata[i]), 64'd0);
      check("rst_c_rdata",   64'(c_rdata[i]),   64'd0);
      check("rst_d_rdata",   64'(d_rdata[i]),   64'd0);
      check("rst_gnt_done",  64'({c_gnt[i], d_gnt[i], c_done[i], d_done[i]}), 64'd0);
    end
    @(posedge clk); #1;

    // C write 0x05 = DEADBEEF
    t = cyc;
    c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 9'h05; c_wdata[0] = 32'hDEADBEEF;
    exp_gnt(0, 1'b0, t + 1);
    exp_done(0, 1'b0, t + 2, 1'b0, '0, '0);
    wait_cyc(t + 1);
    c_req[0] = 1'b0;
    @(negedge clk);
    check("wr_ram_we",    64'(ram_we[0]),    64'd1);
    check("wr_ram_addr",  64'(ram_addr[0]),  64'h05);
    check("wr_ram_wdata", 64'(ram_wdata[0]), 64'hDEADBEEF);
    wait_cyc(t + 2);
    @(negedge clk);
    check("wr_ram_we_off", 64'(ram_we[0]), 64'd0);

    // C read 0x05
    wait_cyc(t + 3);
    t = cyc;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 9'h05;
    exp_gnt(0, 1'b0, t + 1);
    exp_done(0, 1'b0, t + 3, 1'b1, 32'hDEADBEEF, 32'h0);
    wait_cyc(t + 1);
    c_req[0] = 1'b0;

    // D writes 0x1FF while C already waits to read 0x1FF: D first (owner=C), then C
    wait_cyc(t + 4);
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 9'h1FF; d_wdata[0] = 32'h12345678;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 9'h1FF;
    exp_gnt(0, 1'b1, t + 1);
    exp_done(0, 1'b1, t + 2, 1'b0, '0, '0);
    exp_gnt(0, 1'b0, t + 4);
    exp_done(0, 1'b0, t + 6, 1'b1, 32'h12345678, 32'h0);
    wait_cyc(t + 1);
    d_req[0] = 1'b0;
    wait_cyc(t + 4);
    c_req[0] = 1'b0;

    // C read aborted by reset in WAIT; then a normal read
    wait_cyc(t + 7);
    t = cyc;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 9'h05;
    exp_gnt(0, 1'b0, t + 1);
    wait_cyc(t + 1);
    c_req[0] = 1'b0;
    wait_cyc(t + 2);
    rst[0] = 1'b1;
    wait_cyc(t + 3);
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_busy",    64'(busy[0]),    64'd0);
    check("abort_c_rdata", 64'(c_rdata[0]), 64'd0);
    check("abort_c_done",  64'(c_done[0]),  64'd0);
    @(posedge clk); #1;
    t = cyc;
    c_req[0] = 1'b1;
    exp_gnt(0, 1'b0, t + 1);
    exp_done(0, 1'b0, t + 3, 1'b1, 32'hDEADBEEF, 32'h0);
    wait_cyc(t + 1);
    c_req[0] = 1'b0;

    // Both held after reset: C, D, C, D
    wait_cyc(t + 4);
    pulse_rst(0);
    t = cyc;
    c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 9'h010; c_wdata[0] = 32'h11111111;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 9'h020; d_wdata[0] = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      exp_gnt(0, k[0], t + 1 + 3 * k);
      exp_done(0, k[0], t + 2 + 3 * k, 1'b0, '0, '0);
    end
    wait_cyc(t + 11);
    c_req[0] = 1'b0;
    d_req[0] = 1'b0;

    // Reset during a D write's ACCESS: the write must not land
    wait_cyc(t + 12);
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 9'h030; d_wdata[0] = 32'hAAAA5555;
    exp_gnt(0, 1'b1, t + 1);
    wait_cyc(t + 1);
    d_req[0] = 1'b0;
    rst[0] = 1'b1;
    wait_cyc(t + 2);
    rst[0] = 1'b0;
    @(negedge clk);
    check("acc_abort_busy",  64'(busy[0]),  64'd0);
    check("acc_abort_owner", 64'(owner[0]), 64'd1);
    @(posedge clk); #1;
    t = cyc;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 9'h030;
    exp_gnt(0, 1'b0, t + 1);
    exp_done(0, 1'b0, t + 3, 1'b1, 32'h0, 32'h0);
    wait_cyc(t + 1);
    c_req[0] = 1'b0;
    wait_cyc(t + 4);

    // RD_LAT=3 instance: write then read, req dropped right after gnt
    t = cyc;
    c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 9'h007; c_wdata[1] = 32'hCAFEF00D;
    exp_gnt(1, 1'b0, t + 1);
    exp_done(1, 1'b0, t + 2, 1'b0, '0, '0);
    wait_cyc(t + 1);
    c_req[1] = 1'b0;
    wait_cyc(t + 3);
    t = cyc;
    c_req[1] = 1'b1; c_we[1] = 1'b0;
    exp_gnt(1, 1'b0, t + 1);
    exp_done(1, 1'b0, t + 5, 1'b1, 32'hCAFEF00D, 32'h0);
    wait_cyc(t + 1);
    c_req[1] = 1'b0;
    wait_cyc(t + 3);
    @(negedge clk);
    check("lat3_wait_busy",   64'(busy[1]),   64'd1);
    check("lat3_wait_ram_we", 64'(ram_we[1]), 64'd0);
    check("lat3_wait_addr",   64'(ram_addr[1]), 64'h007);
    wait_cyc(t + 8);

    check("gnt_queue_empty",  64'(gq.size()), 64'd0);
    check("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
